score_request_arbiter: RTL and testbench
========================================

Name: score_request_arbiter

Overview:
- Shares the single BCD score accumulator (6 digits, add/remove enables, 24-bit amount) among NUM_REQ independent score-event sources (hits, bonuses, penalties).
- Buffers one pending request per source and grants round-robin.
- Clamps each amount so the score never underflows below 000000 or overflows past 999999.
- Sits between the game-object collision logic and the score accumulator; it is the only driver of the accumulator's enables and amount.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..8).
- DIGITS, 6, BCD digits per amount/score; field width W = 4*DIGITS.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- reqValid  in  NUM_REQ  per-source request strobe, one cycle per event
- reqRemove  in  NUM_REQ  per-source op select: 1 = subtract, 0 = add
- reqAmount  in  NUM_REQ*W  source k amount in bits [k*W +: W], BCD, same digit order as the accumulator amount
- freeze  in  1  game paused; inhibits new grants
- scoreIn  in  W  current accumulator result
- enableAdd  out  1  accumulator add enable
- enableRemove  out  1  accumulator remove enable
- amountOut  out  W  clamped amount to accumulator
- grantPulse  out  NUM_REQ  one-hot, high during the ISSUE cycle of the served source
- busy  out  1  high when FSM is not in IDLE
- dropPulse  out  1  one-cycle pulse per dropped/rejected request
- dropCount  out  8  saturating count of dropped/rejected requests

Behaviour:
- Reset (async, resetN low): all outputs 0; all pending slots empty; FSM in IDLE; RR pointer set so source 0 has top priority.
- Capture: reqValid[k] with slot k empty → latch op and amount at that edge.
  - Slot k full and not being freed this cycle → request dropped: dropPulse=1 next cycle, dropCount +1 (saturates at 255).
  - Slot k is freed at the end of ISSUE for k; a request arriving in that same cycle is captured, not dropped.
- Validation: any amount nibble > 9 → request rejected, handled exactly as a drop, never captured.
- Multiple drops in one cycle: dropCount adds the number of drops (saturating); dropPulse=1.
- FSM states:
  - IDLE: if freeze=0 and any slot pending, select winner by round-robin starting at (last granted + 1) mod NUM_REQ. Register winner index and effective amount → ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): exactly one of enableAdd/enableRemove = 1, amountOut valid, grantPulse[winner] = 1. Winner slot cleared; RR pointer = winner. → SETTLE.
  - SETTLE (1 cycle): all enables 0; lets scoreIn reflect the update. → IDLE.
- Enables, amountOut and grantPulse are 0 outside ISSUE.
- Latency: request at cycle 0 → captured at edge 0/1 → IDLE decision in cycle 1 → ISSUE in cycle 2. Throughput is one update per 3 cycles.
- Clamp, computed in IDLE from scoreIn (digit-wise BCD):
  - Add: if score + amount > 999999, amount = nines' complement of score (9 − d per digit), so the result is exactly 999999.
  - Remove: if amount > score (BCD magnitude compare, most-significant digit first), amount = score, so the result is 000000.
- freeze: blocks only the IDLE→ISSUE transition. ISSUE/SETTLE in progress complete; requests are still captured/dropped normally.
- Reset mid-operation: enables drop to 0 immediately (async); all pending requests discarded.

Test Plan:
- Single add: score 000120, source 1 add 000050 at cycle 0 → enableAdd=1, amountOut=000050, grantPulse=0010 in cycle 2; busy cycles 2–3; score 000170.
- Round-robin: all 4 sources request the same cycle with source 2 last granted → grant order 3,0,1,2 at cycles 2,5,8,11; no drops.
- Overflow clamp: score 999950, add 000100 → amountOut=000049, score 999999. Underflow clamp: score 000030, remove 000100 → enableRemove=1, amountOut=000030, score 000000.
- Drop/reject: source 0 requests twice while its first is pending → one dropPulse, dropCount=1. A request carrying nibble 0xA → rejected, dropCount=2.
- Same-cycle free: source 0 re-requests in its own ISSUE cycle → captured, served at the next grant, no drop.
- freeze held 10 cycles with 2 pending → no enables; after release, grants resume in 3-cycle cadence. Assert resetN during ISSUE → enables 0 immediately, slots empty, dropCount=0.

Source files
------------

// File: rtl/score_request_arbiter.sv
// Round-robin arbiter that serialises score events from NUM_REQ sources onto one
// BCD score accumulator, clamping each amount so the score stays within 0..all-nines.
module score_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DIGITS  = 6,
    localparam int W      = 4 * DIGITS,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [NUM_REQ-1:0]   reqRemove,
    input  logic [NUM_REQ*W-1:0] reqAmount,
    input  logic                 freeze,
    input  logic [W-1:0]         scoreIn,
    output logic                 enableAdd,
    output logic                 enableRemove,
    output logic [W-1:0]         amountOut,
    output logic [NUM_REQ-1:0]   grantPulse,
    output logic                 busy,
    output logic                 dropPulse,
    output logic [7:0]           dropCount
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]         state;
    logic [NUM_REQ-1:0] slot_valid;
    logic [NUM_REQ-1:0] slot_remove;
    logic [W-1:0]       slot_amount [NUM_REQ];
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_remove;
    logic [W-1:0]       win_amount;

    logic [NUM_REQ-1:0] capture;
    logic [NUM_REQ-1:0] drop;
    logic [NUM_REQ-1:0] freeing;
    logic [3:0]         drop_num;
    logic [8:0]         drop_sum;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               sel_remove;
    logic [W-1:0]       sel_amount;
    logic [W-1:0]       nines;
    logic [W-1:0]       clamped;

    function automatic logic bcd_ok(input logic [W-1:0] value);
        bcd_ok = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (value[4*d +: 4] > 4'd9) bcd_ok = 1'b0;
    endfunction

    // A slot being served this cycle counts as empty, so a same-cycle re-request is kept.
    always_comb begin
        capture  = '0;
        drop     = '0;
        freeing  = '0;
        drop_num = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            freeing[k] = (state == ST_ISSUE) && (win_idx == IDX_W'(k));
            if (reqValid[k]) begin
                if (bcd_ok(reqAmount[k*W +: W]) && (!slot_valid[k] || freeing[k]))
                    capture[k] = 1'b1;
                else
                    drop[k] = 1'b1;
            end
            drop_num = drop_num + {3'b000, drop[k]};
        end
        drop_sum = {1'b0, dropCount} + {5'b00000, drop_num};
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!pick_found && slot_valid[(int'(last_grant) + off) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            end
        end
    end

    // With valid BCD digits, a plain unsigned compare is the digit-wise magnitude compare.
    always_comb begin
        sel_remove = slot_remove[pick_idx];
        sel_amount = slot_amount[pick_idx];
        nines      = '0;
        for (int d = 0; d < DIGITS; d++)
            nines[4*d +: 4] = 4'd9 - scoreIn[4*d +: 4];
        if (sel_remove)
            clamped = (sel_amount > scoreIn) ? scoreIn : sel_amount;
        else
            clamped = (sel_amount > nines) ? nines : sel_amount;
    end

    // NOTE: slot payloads are qualified by slot_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (capture[k]) begin
                slot_remove[k] <= reqRemove[k];
                slot_amount[k] <= reqAmount[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slot_valid <= '0;
            dropPulse  <= 1'b0;
            dropCount  <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (capture[k])      slot_valid[k] <= 1'b1;
                else if (freeing[k]) slot_valid[k] <= 1'b0;
            end
            dropPulse <= |drop;
            dropCount <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            win_idx    <= '0;
            win_remove <= 1'b0;
            win_amount <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!freeze && pick_found) begin
                        win_idx    <= pick_idx;
                        win_remove <= sel_remove;
                        win_amount <= clamped;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    last_grant <= win_idx;
                    state      <= ST_SETTLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers so reset clears them without waiting for a clock.
    always_comb begin
        enableAdd    = (state == ST_ISSUE) && !win_remove;
        enableRemove = (state == ST_ISSUE) && win_remove;
        amountOut    = (state == ST_ISSUE) ? win_amount : '0;
        grantPulse   = '0;
        if (state == ST_ISSUE) grantPulse[win_idx] = 1'b1;
        busy         = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_score_request_arbiter.sv
// Directed bench for score_request_arbiter with a behavioural BCD accumulator
// feeding scoreIn back, so clamp results show up as final score values.
module tb_score_request_arbiter;

    localparam int N = 4;
    localparam int W = 24;

    logic           clk = 1'b0;
    logic           resetN;
    logic [N-1:0]   reqValid;
    logic [N-1:0]   reqRemove;
    logic [N*W-1:0] reqAmount;
    logic           freeze;
    logic [W-1:0]   scoreIn;
    logic           enableAdd;
    logic           enableRemove;
    logic [W-1:0]   amountOut;
    logic [N-1:0]   grantPulse;
    logic           busy;
    logic           dropPulse;
    logic [7:0]     dropCount;

    logic           load;
    logic [W-1:0]   load_val;
    int             tests = 0;
    int             fails = 0;

    score_request_arbiter #(.NUM_REQ(N), .DIGITS(6)) dut (
        .clk(clk), .resetN(resetN), .reqValid(reqValid), .reqRemove(reqRemove),
        .reqAmount(reqAmount), .freeze(freeze), .scoreIn(scoreIn),
        .enableAdd(enableAdd), .enableRemove(enableRemove), .amountOut(amountOut),
        .grantPulse(grantPulse), .busy(busy), .dropPulse(dropPulse), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    function automatic int from_bcd(input logic [W-1:0] v);
        from_bcd = 0;
        for (int d = 5; d >= 0; d--) from_bcd = from_bcd * 10 + int'(v[4*d +: 4]);
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        int r = v;
        to_bcd = '0;
        for (int d = 0; d < 6; d++) begin
            to_bcd[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    // Accumulator model: the score register the arbiter drives.
    always @(posedge clk) begin
        if (load)              scoreIn <= load_val;
        else if (enableAdd)    scoreIn <= to_bcd(from_bcd(scoreIn) + from_bcd(amountOut));
        else if (enableRemove) scoreIn <= to_bcd(from_bcd(scoreIn) - from_bcd(amountOut));
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_score(input logic [W-1:0] v);
        load = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] v, input logic [N-1:0] rm, input logic [N*W-1:0] a);
        reqValid = v;
        reqRemove = rm;
        reqAmount = a;
        tick();
        reqValid = '0;
        reqRemove = '0;
        reqAmount = '0;
    endtask

    initial begin
        resetN = 1'b0;
        reqValid = '0;
        reqRemove = '0;
        reqAmount = '0;
        freeze = 1'b0;
        load = 1'b0;
        load_val = '0;
        scoreIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enables", 32'({enableAdd, enableRemove}), 32'd0);
        check("rst_grant", 32'(grantPulse), 32'd0);
        check("rst_busy_drop", 32'({busy, dropPulse, dropCount}), 32'd0);
        resetN = 1'b1;

        // Single add: 000120 + 000050
        set_score(24'h000120);
        pulse(4'b0010, 4'b0000, {24'h0, 24'h0, 24'h000050, 24'h0});
        check("add_c1_busy", 32'(busy), 32'd0);
        tick();
        check("add_c2_en", 32'({enableAdd, enableRemove}), 32'b10);
        check("add_c2_amount", 32'(amountOut), 32'h000050);
        check("add_c2_grant", 32'(grantPulse), 32'b0010);
        check("add_c2_busy", 32'(busy), 32'd1);
        tick();
        check("add_c3_busy_en", 32'({busy, enableAdd, grantPulse}), 32'b1_0_0000);
        check("add_score", 32'(scoreIn), 32'h000170);
        tick();
        check("add_c4_busy", 32'(busy), 32'd0);

        // Make source 2 the last granted, then all four request at once
        pulse(4'b0100, 4'b0000, {24'h0, 24'h000001, 24'h0, 24'h0});
        repeat (3) tick();
        pulse(4'b1111, 4'b0000, {24'h000004, 24'h000003, 24'h000002, 24'h000001});
        tick();
        check("rr_grant_3", 32'(grantPulse), 32'b1000);
        repeat (3) tick();
        check("rr_grant_0", 32'(grantPulse), 32'b0001);
        repeat (3) tick();
        check("rr_grant_1", 32'(grantPulse), 32'b0010);
        repeat (3) tick();
        check("rr_grant_2", 32'(grantPulse), 32'b0100);
        repeat (2) tick();
        check("rr_drops", 32'(dropCount), 32'd0);
        check("rr_score", 32'(scoreIn), 32'h000181);

        // Overflow clamp
        set_score(24'h999950);
        pulse(4'b0001, 4'b0000, {24'h0, 24'h0, 24'h0, 24'h000100});
        tick();
        check("ovf_amount", 32'(amountOut), 32'h000049);
        check("ovf_en", 32'({enableAdd, enableRemove}), 32'b10);
        tick();
        check("ovf_score", 32'(scoreIn), 32'h999999);
        tick();

        // Underflow clamp
        set_score(24'h000030);
        pulse(4'b0010, 4'b0010, {24'h0, 24'h0, 24'h000100, 24'h0});
        tick();
        check("unf_en", 32'({enableAdd, enableRemove}), 32'b01);
        check("unf_amount", 32'(amountOut), 32'h000030);
        tick();
        check("unf_score", 32'(scoreIn), 32'h000000);
        tick();

        // Drop: source 0 requests again while its slot is pending
        pulse(4'b0001, 4'b0000, {24'h0, 24'h0, 24'h0, 24'h000001});
        pulse(4'b0001, 4'b0000, {24'h0, 24'h0, 24'h0, 24'h000002});
        check("drop_pulse", 32'(dropPulse), 32'd1);
        check("drop_count1", 32'(dropCount), 32'd1);
        check("drop_grant", 32'(grantPulse), 32'b0001);
        check("drop_amount", 32'(amountOut), 32'h000001);
        tick();
        check("drop_pulse_end", 32'(dropPulse), 32'd0);
        tick();

        // Reject: non-BCD nibble
        pulse(4'b0100, 4'b0000, {24'h0, 24'h00000A, 24'h0, 24'h0});
        check("rej_pulse", 32'(dropPulse), 32'd1);
        check("rej_count2", 32'(dropCount), 32'd2);
        tick();
        check("rej_not_captured", 32'({busy, enableAdd}), 32'd0);

        // Same-cycle free: re-request during own ISSUE is kept
        pulse(4'b0001, 4'b0000, {24'h0, 24'h0, 24'h0, 24'h000003});
        tick();
        check("sfree_grant1", 32'(grantPulse), 32'b0001);
        pulse(4'b0001, 4'b0000, {24'h0, 24'h0, 24'h0, 24'h000004});
        check("sfree_no_drop", 32'({dropPulse, dropCount}), 32'({1'b0, 8'd2}));
        repeat (2) tick();
        check("sfree_grant2", 32'(grantPulse), 32'b0001);
        check("sfree_amount2", 32'(amountOut), 32'h000004);
        repeat (2) tick();
        check("sfree_score", 32'(scoreIn), 32'h000008);

        // Freeze with two pending
        freeze = 1'b1;
        pulse(4'b1010, 4'b0000, {24'h000006, 24'h0, 24'h000005, 24'h0});
        for (int i = 0; i < 10; i++) begin
            check("frz_idle", 32'({busy, enableAdd, enableRemove}), 32'd0);
            tick();
        end
        freeze = 1'b0;
        tick();
        check("frz_grant1", 32'(grantPulse), 32'b0010);
        repeat (3) tick();
        check("frz_grant3", 32'(grantPulse), 32'b1000);
        repeat (2) tick();
        check("frz_score", 32'(scoreIn), 32'h000019);

        // Reset during ISSUE with another slot pending
        pulse(4'b1100, 4'b0000, {24'h000008, 24'h000007, 24'h0, 24'h0});
        tick();
        check("mrst_pre_grant", 32'({enableAdd, grantPulse}), 32'b1_0100);
        #2 resetN = 1'b0;
        #1;
        check("mrst_enables", 32'({enableAdd, enableRemove, grantPulse}), 32'd0);
        check("mrst_amount", 32'(amountOut), 32'd0);
        check("mrst_busy_count", 32'({busy, dropCount}), 32'd0);
        @(posedge clk);
        #1 resetN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mrst_slots_empty", 32'({busy, enableAdd, grantPulse}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
